// File: rtl/obs_split_dispatch_34bit_pkg.sv
// Shared constants, tag encodings and FSM state type for the split dispatcher.
package obs_split_dispatch_34bit_pkg;

  // Operand width in coefficients (must be even), half width, sub-product width.
  localparam int N  = 34;
  localparam int H  = N / 2;
  localparam int PW = 2 * H - 1;

  // Fixed sub-product tag map: which halves of A and B feed each tag.
  localparam logic [1:0] TAG_EE = 2'd0;  // (Ae, Be)
  localparam logic [1:0] TAG_EO = 2'd1;  // (Ae, Bo)
  localparam logic [1:0] TAG_OE = 2'd2;  // (Ao, Be)
  localparam logic [1:0] TAG_OO = 2'd3;  // (Ao, Bo)

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/obs_split_dispatch_34bit_split.sv
// Combinational even/odd de-interleave of one GF(2) polynomial operand.
module obs_even_odd_split
  import obs_split_dispatch_34bit_pkg::*;
#(
  parameter int n = N
) (
  input  logic [n-1:0]   op,
  output logic [n/2-1:0] even,
  output logic [n/2-1:0] odd
);

  // Coefficient 2k goes to even[k], coefficient 2k+1 goes to odd[k].
  always_comb begin
    even = '0;
    odd  = '0;
    for (int k = 0; k < n / 2; k++) begin
      even[k] = op[2*k];
      odd[k]  = op[2*k+1];
    end
  end

endmodule

// File: rtl/obs_split_dispatch_34bit.sv
// Splits two n-bit GF(2) operands into even/odd halves, issues the four
// half-size sub-products to a shared multiplier and collects the results
// (in any order) for the downstream overlap stage.
module obs_split_dispatch_34bit
  import obs_split_dispatch_34bit_pkg::*;
#(
  parameter int n = N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [n-1:0]   a_in,
  input  logic [n-1:0]   b_in,
  output logic           sub_valid,
  input  logic           sub_ready,
  output logic [n/2-1:0] sub_a,
  output logic [n/2-1:0] sub_b,
  output logic [1:0]     sub_tag,
  input  logic           res_valid,
  input  logic [1:0]     res_tag,
  input  logic [n-2:0]   res_data,
  output logic [n-2:0]   p1,
  output logic [n-2:0]   p2,
  output logic [n-2:0]   p3,
  output logic [n-2:0]   p4,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           err
);

  localparam int h = n / 2;

  logic [h-1:0] a_even_s, a_odd_s, b_even_s, b_odd_s;
  logic [h-1:0] ae_r, ao_r, be_r, bo_r;
  state_t       state_r, state_s;
  logic [2:0]   cnt_r;     // next tag to issue; reaches 4 once all are issued
  logic [3:0]   mask_r;    // one bit per tag whose result has been stored
  logic         accept_s, issue_s, res_issued_s, res_ok_s;

  obs_even_odd_split #(.n(n)) u_split_a (.op(a_in), .even(a_even_s), .odd(a_odd_s));
  obs_even_odd_split #(.n(n)) u_split_b (.op(b_in), .even(b_even_s), .odd(b_odd_s));

  assign accept_s = in_valid & in_ready;
  assign issue_s  = sub_valid & sub_ready;
  assign sub_tag  = cnt_r[1:0];

  // A result is legal for a tag already issued, or the one handshaking now.
  assign res_issued_s = ({1'b0, res_tag} < cnt_r) ||
                        (issue_s && (res_tag == cnt_r[1:0]));
  assign res_ok_s     = res_valid && ((state_r == ISSUE) || (state_r == WAIT)) &&
                        res_issued_s && !mask_r[res_tag];

  // Next-state and handshake decode from the registered state.
  always_comb begin
    state_s   = state_r;
    in_ready  = 1'b0;
    sub_valid = 1'b0;
    out_valid = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_s = ISSUE;
        else          state_s = IDLE;
      end
      ISSUE: begin
        sub_valid = 1'b1;
        if (sub_ready && (cnt_r == 3'd3)) begin
          if (mask_r == 4'hF) state_s = DONE;
          else                state_s = WAIT;
        end else begin
          state_s = ISSUE;
        end
      end
      WAIT: begin
        if (mask_r == 4'hF) state_s = DONE;
        else                state_s = WAIT;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Operand selection for the tag currently being offered.
  always_comb begin
    case (cnt_r[1:0])
      TAG_EE:  begin sub_a = ae_r; sub_b = be_r; end
      TAG_EO:  begin sub_a = ae_r; sub_b = bo_r; end
      TAG_OE:  begin sub_a = ao_r; sub_b = be_r; end
      TAG_OO:  begin sub_a = ao_r; sub_b = bo_r; end
      default: begin sub_a = '0;   sub_b = '0;   end
    endcase
  end

  // State, operand halves, issue counter, result collection and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= 3'd0;
      mask_r  <= 4'h0;
      ae_r    <= '0;
      ao_r    <= '0;
      be_r    <= '0;
      bo_r    <= '0;
      p1      <= '0;
      p2      <= '0;
      p3      <= '0;
      p4      <= '0;
      err     <= 1'b0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        ae_r   <= a_even_s;
        ao_r   <= a_odd_s;
        be_r   <= b_even_s;
        bo_r   <= b_odd_s;
        cnt_r  <= 3'd0;
        mask_r <= 4'h0;
      end else begin
        if (issue_s) cnt_r <= cnt_r + 3'd1;
        if (res_ok_s) begin
          mask_r[res_tag] <= 1'b1;
          case (res_tag)
            TAG_EE:  p1 <= res_data;
            TAG_EO:  p2 <= res_data;
            TAG_OE:  p3 <= res_data;
            TAG_OO:  p4 <= res_data;
            default: p1 <= p1;
          endcase
        end
      end
      if (res_valid && !res_ok_s) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_obs_split_dispatch_34bit.sv
// Directed self-checking bench for obs_split_dispatch_34bit.
module tb_obs_split_dispatch_34bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [33:0] a_in, b_in;
  logic        sub_valid, sub_ready;
  logic [16:0] sub_a, sub_b;
  logic [1:0]  sub_tag;
  logic        res_valid;
  logic [1:0]  res_tag;
  logic [32:0] res_data;
  logic [32:0] p1, p2, p3, p4;
  logic        out_valid, out_ready, err;

  int checks = 0;
  int fails  = 0;

  // Result source: 1-cycle multiplier model (auto) or task-driven (manual).
  logic        auto_mode = 1'b1;
  logic        m_valid = 1'b0;
  logic [1:0]  m_tag = 2'd0;
  logic [32:0] m_data = 33'd0;
  logic        t_valid = 1'b0;
  logic [1:0]  t_tag = 2'd0;
  logic [32:0] t_data = 33'd0;
  logic [35:0] issue_log [$];

  assign res_valid = auto_mode ? m_valid : t_valid;
  assign res_tag   = auto_mode ? m_tag   : t_tag;
  assign res_data  = auto_mode ? m_data  : t_data;

  always #5 clk = ~clk;

  obs_split_dispatch_34bit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .sub_valid(sub_valid), .sub_ready(sub_ready),
    .sub_a(sub_a), .sub_b(sub_b), .sub_tag(sub_tag), .res_valid(res_valid),
    .res_tag(res_tag), .res_data(res_data), .p1(p1), .p2(p2), .p3(p3), .p4(p4),
    .out_valid(out_valid), .out_ready(out_ready), .err(err)
  );

  function automatic logic [32:0] gmul(input logic [16:0] x, input logic [16:0] y);
    logic [32:0] r = 33'd0;
    for (int i = 0; i < 17; i++) if (y[i]) r = r ^ ({16'd0, x} << i);
    return r;
  endfunction

  function automatic logic [16:0] ev(input logic [33:0] v);
    logic [16:0] r = 17'd0;
    for (int k = 0; k < 17; k++) r[k] = v[2*k];
    return r;
  endfunction

  function automatic logic [16:0] od(input logic [33:0] v);
    logic [16:0] r = 17'd0;
    for (int k = 0; k < 17; k++) r[k] = v[2*k+1];
    return r;
  endfunction

  function automatic logic [66:0] spread(input logic [32:0] v);
    logic [66:0] r = 67'd0;
    for (int j = 0; j < 33; j++) r[2*j] = v[j];
    return r;
  endfunction

  // Expected {tag, sub_a, sub_b} for a tag of the operation (a, b).
  function automatic logic [35:0] exp_issue(input int t, input logic [33:0] a, input logic [33:0] b);
    logic [16:0] xa, xb;
    xa = (t >= 2) ? od(a) : ev(a);
    xb = (t % 2 == 1) ? od(b) : ev(b);
    return {t[1:0], xa, xb};
  endfunction

  // Multiplier model.
  always @(posedge clk) begin
    m_valid <= auto_mode && sub_valid && sub_ready;
    m_tag   <= sub_tag;
    m_data  <= gmul(sub_a, sub_b);
  end

  // Issue monitor.
  always @(posedge clk) begin
    if (rst_n && sub_valid && sub_ready) issue_log.push_back({sub_tag, sub_a, sub_b});
  end

  task automatic start_op(input logic [33:0] a, input logic [33:0] b);
    @(negedge clk);
    in_valid = 1'b1; a_in = a; b_in = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (!out_valid && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL done_timeout: out_valid=%b after %0d cycles, required 1", out_valid, cycles);
    end
  endtask

  task automatic wait_issues(input int base, input int budget);
    int c = 0;
    while ((issue_log.size() - base) < 4 && c < budget) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if ((issue_log.size() - base) != 4) begin
      fails++;
      $display("FAIL issue_count: got %0d issues, required 4", issue_log.size() - base);
    end
  endtask

  task automatic finish_op();
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL back_to_idle: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic send_res(input logic [1:0] t, input logic [32:0] d);
    @(negedge clk);
    t_valid = 1'b1; t_tag = t; t_data = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; a_in = 34'd0; b_in = 34'd0;
    sub_ready = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sub_valid !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0 ||
        p1 !== 33'd0 || p2 !== 33'd0 || p3 !== 33'd0 || p4 !== 33'd0) begin
      fails++;
      $display("FAIL reset_outputs: sv=%b ov=%b err=%b p1=%h p2=%h p3=%h p4=%h, required all 0",
               sub_valid, out_valid, err, p1, p2, p3, p4);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int base, cyc;
    logic [35:0] exp_tab [4];
    exp_tab[0] = {2'd0, 17'd1, 17'd1};
    exp_tab[1] = {2'd1, 17'd1, 17'd0};
    exp_tab[2] = {2'd2, 17'd0, 17'd1};
    exp_tab[3] = {2'd3, 17'd0, 17'd0};
    auto_mode = 1'b1; sub_ready = 1'b1;
    base = issue_log.size();
    start_op(34'd1, 34'd1);
    wait_done(20, cyc);
    checks++;
    if (cyc != 6) begin
      fails++;
      $display("FAIL basic_latency: out_valid after %0d cycles, required 6", cyc);
    end
    checks++;
    if (issue_log.size() - base != 4) begin
      fails++;
      $display("FAIL basic_issue_count: got %0d, required 4", issue_log.size() - base);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (issue_log[base+k] !== exp_tab[k]) begin
          fails++;
          $display("FAIL basic_issue%0d: got %h, required %h", k, issue_log[base+k], exp_tab[k]);
        end
      end
    end
    checks++;
    if (p1 !== 33'd1 || p2 !== 33'd0 || p3 !== 33'd0 || p4 !== 33'd0 || err !== 1'b0) begin
      fails++;
      $display("FAIL basic_products: p1=%h p2=%h p3=%h p4=%h err=%b, required 1/0/0/0 err 0",
               p1, p2, p3, p4, err);
    end
    finish_op();
  endtask

  task automatic test_x2();
    int base, cyc;
    logic [66:0] ovl;
    base = issue_log.size();
    start_op(34'h2, 34'h2);
    wait_done(20, cyc);
    checks++;
    if (issue_log.size() - base != 4 || issue_log[base+3] !== {2'd3, 17'd1, 17'd1}) begin
      fails++;
      $display("FAIL x2_tag3_ops: count=%0d, required 4 with tag3 operands (1,1)", issue_log.size() - base);
    end
    checks++;
    if (p1 !== 33'd0 || p2 !== 33'd0 || p3 !== 33'd0 || p4 !== 33'd1) begin
      fails++;
      $display("FAIL x2_products: p1=%h p2=%h p3=%h p4=%h, required 0/0/0/1", p1, p2, p3, p4);
    end
    ovl = spread(p1) ^ (spread(p2 ^ p3) << 1) ^ (spread(p4) << 2);
    checks++;
    if (ovl !== 67'h4) begin
      fails++;
      $display("FAIL x2_overlap: got %h, required 4", ovl);
    end
    finish_op();
  endtask

  task automatic test_reorder();
    logic [33:0] a, b;
    logic [35:0] saved;
    logic        saved_vld;
    logic [32:0] e_p [4];
    int          base, cyc, stalls, i;
    logic [1:0]  order [4];
    a = 34'h2_1234_5678; b = 34'h1_DEAD_BEEF;
    e_p[0] = gmul(ev(a), ev(b)); e_p[1] = gmul(ev(a), od(b));
    e_p[2] = gmul(od(a), ev(b)); e_p[3] = gmul(od(a), od(b));
    order[0] = 2'd3; order[1] = 2'd1; order[2] = 2'd0; order[3] = 2'd2;
    auto_mode = 1'b0; sub_ready = 1'b0;
    base = issue_log.size();
    start_op(a, b);
    saved_vld = 1'b0; stalls = 0; i = 0;
    while ((issue_log.size() - base) < 4 && i < 40) begin
      if (saved_vld) begin
        stalls++;
        checks++;
        if ({sub_tag, sub_a, sub_b} !== saved) begin
          fails++;
          $display("FAIL stall_stable: got %h, required %h", {sub_tag, sub_a, sub_b}, saved);
        end
      end
      sub_ready = i[0];
      saved_vld = sub_valid && !sub_ready;
      saved = {sub_tag, sub_a, sub_b};
      @(negedge clk);
      i++;
    end
    sub_ready = 1'b0;
    checks++;
    if (issue_log.size() - base != 4 || stalls == 0) begin
      fails++;
      $display("FAIL reorder_issue: issues=%0d stalls=%0d, required 4 and >0", issue_log.size() - base, stalls);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (issue_log[base+k] !== exp_issue(k, a, b)) begin
          fails++;
          $display("FAIL reorder_issue%0d: got %h, required %h", k, issue_log[base+k], exp_issue(k, a, b));
        end
      end
    end
    for (int k = 0; k < 4; k++) send_res(order[k], e_p[order[k]]);
    @(negedge clk); t_valid = 1'b0;
    wait_done(20, cyc);
    checks++;
    if (p1 !== e_p[0] || p2 !== e_p[1] || p3 !== e_p[2] || p4 !== e_p[3] || err !== 1'b0) begin
      fails++;
      $display("FAIL reorder_products: p1=%h p2=%h p3=%h p4=%h err=%b, required %h %h %h %h err 0",
               p1, p2, p3, p4, err, e_p[0], e_p[1], e_p[2], e_p[3]);
    end
    finish_op();
  endtask

  task automatic test_duplicate();
    int base, cyc;
    auto_mode = 1'b0; sub_ready = 1'b1;
    base = issue_log.size();
    start_op(34'h3, 34'h1);
    wait_issues(base, 20);
    sub_ready = 1'b0;
    send_res(2'd0, 33'd1);
    send_res(2'd1, 33'h0AAA);
    send_res(2'd1, 33'h1555);
    checks++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL dup_err_before: got %b, required 0", err);
    end
    send_res(2'd2, 33'd1);
    checks++;
    if (err !== 1'b1) begin
      fails++;
      $display("FAIL dup_err_set: got %b, required 1", err);
    end
    send_res(2'd3, 33'd0);
    @(negedge clk); t_valid = 1'b0;
    wait_done(20, cyc);
    checks++;
    if (p2 !== 33'h0AAA || err !== 1'b1) begin
      fails++;
      $display("FAIL dup_keep_first: p2=%h err=%b, required 0aaa err 1", p2, err);
    end
    finish_op();
    send_res(2'd0, 33'h1FFFF);
    @(negedge clk); t_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (err !== 1'b1 || p1 !== 33'd1) begin
      fails++;
      $display("FAIL idle_stray: err=%b p1=%h, required err 1 p1 1", err, p1);
    end
  endtask

  task automatic test_reset_mid();
    int base, cyc;
    auto_mode = 1'b0; sub_ready = 1'b1;
    base = issue_log.size();
    start_op(34'h3FFFFFFFF, 34'h3FFFFFFFF);
    wait_issues(base, 20);
    sub_ready = 1'b0;
    send_res(2'd0, 33'h155555555);
    send_res(2'd1, 33'h155555555);
    @(negedge clk); t_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || p1 !== 33'h155555555) begin
      fails++;
      $display("FAIL mid_wait_state: out_valid=%b p1=%h, required 0 and 155555555", out_valid, p1);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sub_valid !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0 ||
        p1 !== 33'd0 || p2 !== 33'd0 || p3 !== 33'd0 || p4 !== 33'd0) begin
      fails++;
      $display("FAIL mid_reset_outputs: sv=%b ov=%b err=%b p1=%h p2=%h, required all 0",
               sub_valid, out_valid, err, p1, p2);
    end
    @(negedge clk); rst_n = 1'b1;
    send_res(2'd2, 33'd7);
    @(negedge clk); t_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || p3 !== 33'd0) begin
      fails++;
      $display("FAIL late_result_err: err=%b p3=%h, required 1 and 0", err, p3);
    end
    auto_mode = 1'b1; sub_ready = 1'b1;
    start_op(34'h3FFFFFFFF, 34'h3FFFFFFFF);
    wait_done(20, cyc);
    checks++;
    if (p1 !== 33'h155555555 || p2 !== 33'h155555555 ||
        p3 !== 33'h155555555 || p4 !== 33'h155555555) begin
      fails++;
      $display("FAIL ones_square: p1=%h p2=%h p3=%h p4=%h, required 155555555 each", p1, p2, p3, p4);
    end
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || p1 !== 33'h155555555 ||
          p2 !== 33'h155555555 || p3 !== 33'h155555555 || p4 !== 33'h155555555) begin
        fails++;
        $display("FAIL hold_cycle%0d: ov=%b ir=%b p1=%h p4=%h, required 1/0 and 155555555",
                 k, out_valid, in_ready, p1, p4);
      end
    end
    finish_op();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_x2();
    test_reorder();
    test_duplicate();
    test_reset_mid();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule
